// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter -- register-file write-back arbiter.
//
// Three result sources (MEM, ALU, MUL) compete for the single register-file
// write port. The fixed priority is MEM > ALU > MUL. A starvation counter
// lets MUL win once it has been denied STARVE_LIM cycles in a row. The
// winning result is registered onto RegWrite/WriteReg/WriteData one cycle
// after the handshake. A write to rd=31 (XZR) is accepted but not written.
//
// Parameters:
//   DATA_W      register data width
//   STARVE_LIM  maximum consecutive cycles a pending MUL request is denied
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   mem_valid/ready/rd/data  load-result handshake
//   alu_valid/ready/rd/data  ALU-result handshake
//   mul_valid/ready/rd/data  multiplier-result handshake
//   RegWrite/WriteReg/WriteData  registered register-file write port
//
// Optional feature (macro WB_FWD_EN):
//   fwd_valid/fwd_rd/fwd_data give the current-cycle winner combinationally
//   for operand bypass. fwd_valid is 0 for rd=31 or when there is no transfer.
// -----------------------------------------------------------------------------
module wb_arbiter #(
   parameter int DATA_W     = 64,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [4:0]        mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [4:0]        alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mul_valid,
   output logic              mul_ready,
   input  logic [4:0]        mul_rd,
   input  logic [DATA_W-1:0] mul_data,
   output logic              RegWrite,
   output logic [4:0]        WriteReg,
   output logic [DATA_W-1:0] WriteData
`ifdef WB_FWD_EN
   ,
   output logic              fwd_valid,
   output logic [4:0]        fwd_rd,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   localparam int CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
   localparam logic [4:0] XZR = 5'd31;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_MEM  = 2'd1,
      SRC_ALU  = 2'd2,
      SRC_MUL  = 2'd3
   } src_e;

   logic [CNT_W-1:0]  r_starve;
   logic              w_starved;
   src_e              w_sel;
   logic              w_xfer;
   logic [4:0]        w_rd;
   logic [DATA_W-1:0] w_data;

   assign w_starved = mul_valid && (r_starve == CNT_W'(STARVE_LIM));

   // Pick the winner; reset holds every ready low so no transfer can happen.
   always_comb begin
      w_sel = SRC_NONE;
      if (!rst_n) begin
         w_sel = SRC_NONE;
      end else if (w_starved) begin
         w_sel = SRC_MUL;
      end else if (mem_valid) begin
         w_sel = SRC_MEM;
      end else if (alu_valid) begin
         w_sel = SRC_ALU;
      end else if (mul_valid) begin
         w_sel = SRC_MUL;
      end else begin
         w_sel = SRC_NONE;
      end
   end

   assign mem_ready = (w_sel == SRC_MEM);
   assign alu_ready = (w_sel == SRC_ALU);
   assign mul_ready = (w_sel == SRC_MUL);
   assign w_xfer    = (w_sel != SRC_NONE);

   // Route the winner's destination and data.
   always_comb begin
      w_rd   = 5'd0;
      w_data = '0;
      case (w_sel)
         SRC_MEM: begin
            w_rd   = mem_rd;
            w_data = mem_data;
         end
         SRC_ALU: begin
            w_rd   = alu_rd;
            w_data = alu_data;
         end
         SRC_MUL: begin
            w_rd   = mul_rd;
            w_data = mul_data;
         end
         default: begin
            w_rd   = 5'd0;
            w_data = '0;
         end
      endcase
   end

`ifdef WB_FWD_EN
   assign fwd_valid = w_xfer && (w_rd != XZR);
   assign fwd_rd    = w_rd;
   assign fwd_data  = w_data;
`endif

   // Write-back register and MUL starvation counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWrite  <= 1'b0;
         WriteReg  <= 5'd0;
         WriteData <= '0;
         r_starve  <= '0;
      end else begin
         if (w_xfer) begin
            // XZR writes are consumed but never reach the register file.
            RegWrite  <= (w_rd != XZR);
            WriteReg  <= w_rd;
            WriteData <= w_data;
         end else begin
            RegWrite  <= 1'b0;
         end
         // Count only denied MUL requests; a grant or an idle MUL clears it.
         if (mul_valid && !mul_ready) begin
            if (r_starve == CNT_W'(STARVE_LIM)) begin
               r_starve <= r_starve;
            end else begin
               r_starve <= r_starve + CNT_W'(1);
            end
         end else begin
            r_starve <= '0;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter -- self-checking bench for wb_arbiter.
// A reference arbitration model predicts readies each cycle and pushes the
// expected write-back onto a scoreboard queue; the entry is popped and
// compared once the DUT registers its result. Define WB_FWD_EN to also check
// the bypass outputs.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

   localparam int DW  = 64;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mem_valid, alu_valid, mul_valid;
   logic          mem_ready, alu_ready, mul_ready;
   logic [4:0]    mem_rd, alu_rd, mul_rd;
   logic [DW-1:0] mem_data, alu_data, mul_data;
   logic          RegWrite;
   logic [4:0]    WriteReg;
   logic [DW-1:0] WriteData;
`ifdef WB_FWD_EN
   logic          fwd_valid;
   logic [4:0]    fwd_rd;
   logic [DW-1:0] fwd_data;
`endif

   typedef struct packed {
      logic          we;
      logic [4:0]    rd;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   int            checks = 0;
   int            errors = 0;
   int            m_cnt  = 0;
   logic [4:0]    m_rd_hold   = 5'd0;
   logic [DW-1:0] m_data_hold = '0;

   always #5 clk = ~clk;

   wb_arbiter #(.DATA_W(DW), .STARVE_LIM(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_rd(mul_rd), .mul_data(mul_data),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
`ifdef WB_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
   );

   // One clock of arbitration: predict at the falling edge, compare after the rising edge.
   task automatic step(input string tag);
      logic gm, ga, gu;
      logic [4:0] rd;
      logic [DW-1:0] d;
      exp_t e, got;
      @(negedge clk);
      gm = 1'b0; ga = 1'b0; gu = 1'b0;
      if (mul_valid && m_cnt == LIM) gu = 1'b1;
      else if (mem_valid)            gm = 1'b1;
      else if (alu_valid)            ga = 1'b1;
      else if (mul_valid)            gu = 1'b1;
      checks++;
      if ({mem_ready, alu_ready, mul_ready} !== {gm, ga, gu}) begin
         errors++;
         $display("FAIL %s ready: got %b expected %b", tag,
                  {mem_ready, alu_ready, mul_ready}, {gm, ga, gu});
      end
      rd = gm ? mem_rd   : ga ? alu_rd   : gu ? mul_rd   : m_rd_hold;
      d  = gm ? mem_data : ga ? alu_data : gu ? mul_data : m_data_hold;
      if (gm || ga || gu) begin
         e.we = (rd != 5'd31); e.rd = rd; e.data = d;
         m_rd_hold = rd; m_data_hold = d;
      end else begin
         e.we = 1'b0; e.rd = m_rd_hold; e.data = m_data_hold;
      end
`ifdef WB_FWD_EN
      checks++;
      if (fwd_valid !== e.we || (e.we && (fwd_rd !== rd || fwd_data !== d))) begin
         errors++;
         $display("FAIL %s fwd: got %b/%0d/%h expected %b/%0d/%h", tag,
                  fwd_valid, fwd_rd, fwd_data, e.we, rd, d);
      end
`endif
      sb.push_back(e);
      if (mul_valid && !gu) m_cnt = (m_cnt == LIM) ? LIM : m_cnt + 1;
      else                  m_cnt = 0;
      @(posedge clk);
      #1;
      got = {RegWrite, WriteReg, WriteData};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s wb: got we=%b rd=%0d data=%h expected we=%b rd=%0d data=%h",
                  tag, got.we, got.rd, got.data, e.we, e.rd, e.data);
      end
   endtask

   task automatic idle_inputs();
      mem_valid = 1'b0; alu_valid = 1'b0; mul_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 64'h1111;
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'h2222;
      mul_valid = 1'b1; mul_rd = 5'd3; mul_data = 64'h3333;
      #12;
      checks++;
      if ({mem_ready, alu_ready, mul_ready} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 000", {mem_ready, alu_ready, mul_ready});
      end
      checks++;
      if ({RegWrite, WriteReg, WriteData} !== {1'b0, 5'd0, 64'h0}) begin
         errors++;
         $display("FAIL reset_out: got we=%b rd=%0d data=%h expected zeros", RegWrite, WriteReg, WriteData);
      end
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_priority();
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'hA000_0003;
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'hB000_0004;
      mul_valid = 1'b1; mul_rd = 5'd5; mul_data = 64'hC000_0005;
      step("prio_all");
      mem_valid = 1'b0;
      step("prio_alu_mul");
      alu_valid = 1'b0;
      step("prio_mul");
      idle_inputs();
      step("prio_idle");
   endtask

   task automatic test_xzr();
      alu_valid = 1'b1; alu_rd = 5'd31; alu_data = 64'hDEAD;
      step("xzr");
      idle_inputs();
      step("xzr_idle");
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 3; i++) begin
         alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 64'h50 + 64'(i);
         step("b2b");
      end
      idle_inputs();
      step("b2b_idle");
   endtask

   task automatic test_midreset();
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 64'hFACE;
      mul_valid = 1'b1; mul_rd = 5'd21; mul_data = 64'hBEEF;
      for (int i = 0; i < 3; i++) step("pre_reset");
      checks++;
      if (RegWrite !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre: got RegWrite=%b expected 1", RegWrite);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({RegWrite, WriteReg, WriteData} !== {1'b0, 5'd0, 64'h0} ||
          {mem_ready, alu_ready, mul_ready} !== 3'b000) begin
         errors++;
         $display("FAIL midreset: got we=%b rd=%0d data=%h rdy=%b expected zeros",
                  RegWrite, WriteReg, WriteData, {mem_ready, alu_ready, mul_ready});
      end
      #2;
      rst_n = 1'b1;
      sb.delete();
      m_cnt = 0; m_rd_hold = 5'd0; m_data_hold = '0;
   endtask

   task automatic test_starve();
      // Valids left over from the reset test: ALU rd 20 and MUL rd 21 held.
      for (int i = 0; i < 5; i++) step("starve_alu");
      mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 64'h6666;
      alu_valid = 1'b0;
      mul_rd = 5'd13; mul_data = 64'h1313;
      for (int i = 0; i < 6; i++) step("starve_mem");
      idle_inputs();
      step("starve_idle");
   endtask

   task automatic test_fwd();
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h10;
      step("fwd_mem");
      idle_inputs();
      step("fwd_idle");
   endtask

   initial begin
      test_reset();
      test_priority();
      test_xzr();
      test_back_to_back();
      test_midreset();
      test_starve();
      test_fwd();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
